// File: rtl/nn_load_sequencer_pkg.sv
// Shared types and width helpers for the NN load sequencer.
// Imported by the address counter and the sequencer top.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    RUN,
    DONE
  } nn_seq_state_t;

  localparam int MIN_W = 1;

  // Width of a counter over n values, never below one bit
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : MIN_W;
  endfunction

endpackage

// File: rtl/nn_load_sequencer_if.sv
// Word stream handshake into the NN load sequencer.
// The master drives valid/data and the slave returns ready.
interface nn_load_sequencer_if #(
  parameter int BIT_SIZE = 8
);
  logic                s_valid;
  logic                s_ready;
  logic [BIT_SIZE-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/nn_load_sequencer_addr_counter.sv
// Two-level node/layer counter for the load phases.
// Wraps on exact terminal values; last flags the final slot.
module nn_addr_counter
  import nn_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [clog2w(SIZE)-1:0]   node,
  output logic [clog2w(DEPTH)-1:0]  layer,
  output logic                      last
);
  localparam int NW = clog2w(SIZE);
  localparam int LW = clog2w(DEPTH);

  logic [NW-1:0] node_q, node_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          node_end, layer_end;

  assign node_end  = node_q == NW'(SIZE - 1);
  assign layer_end = layer_q == LW'(DEPTH - 1);

  always_comb begin
    node_d  = node_q;
    layer_d = layer_q;
    if (clr) begin
      node_d  = '0;
      layer_d = '0;
    end else if (inc) begin
      if (node_end) begin
        node_d  = '0;
        layer_d = layer_end ? '0 : layer_q + LW'(1);
      end else begin
        node_d = node_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_q  <= '0;
      layer_q <= '0;
    end else begin
      node_q  <= node_d;
      layer_q <= layer_d;
    end
  end

  assign node  = node_q;
  assign layer = layer_q;
  assign last  = node_end && layer_end;
endmodule

// File: rtl/nn_load_sequencer.sv
// Streams weights then inputs into the NN core, then runs
// the inference window and pulses done.
module nn_load_sequencer
  import nn_pkg::*;
#(
  parameter int LAYER_SIZE  = 3,
  parameter int LAYER_DEPTH = 2,
  parameter int BIT_SIZE    = 8,
  parameter int RUN_TAIL    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            load_weights,
  nn_load_sequencer_if.slave              s,
  output logic                            weight_write_enable,
  output logic                            input_write_enable,
  output logic                            input_select,
  output logic [clog2w(LAYER_DEPTH)-1:0]  addr_layer,
  output logic [clog2w(LAYER_SIZE)-1:0]   addr_node,
  output logic [BIT_SIZE-1:0]             data_in,
  output logic                            busy,
  output logic                            done
);
  localparam int AL      = clog2w(LAYER_DEPTH);
  localparam int AN      = clog2w(LAYER_SIZE);
  localparam int RUN_LEN = LAYER_SIZE * LAYER_DEPTH + RUN_TAIL;
  localparam int RW      = clog2w(RUN_LEN);

  nn_seq_state_t      state_q;
  logic               s_ready_q;
  logic               wwe_q, iwe_q, isel_q;
  logic               busy_q, done_q;
  logic [AL-1:0]      al_q;
  logic [AN-1:0]      an_q;
  logic [BIT_SIZE-1:0] data_q;
  logic [RW-1:0]      run_q;

  logic [AN-1:0] cnt_node;
  logic [AL-1:0] cnt_layer;
  logic          cnt_last;
  logic          acc, ld_w, ld_x, node_end;

  assign acc      = s.s_valid && s_ready_q;
  assign ld_w     = state_q == LOAD_W;
  assign ld_x     = (state_q == LOAD_X) && s_ready_q;
  assign node_end = cnt_node == AN'(LAYER_SIZE - 1);

  nn_addr_counter #(
    .SIZE  (LAYER_SIZE),
    .DEPTH (LAYER_DEPTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (acc && (ld_w || ld_x)),
    .clr   (!(ld_w || ld_x)),
    .node  (cnt_node),
    .layer (cnt_layer),
    .last  (cnt_last)
  );

  // LOAD_X with ready low is the drain cycle of the last input write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      wwe_q     <= 1'b0;
      iwe_q     <= 1'b0;
      isel_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      al_q      <= '0;
      an_q      <= '0;
      data_q    <= '0;
      run_q     <= '0;
    end else begin
      wwe_q  <= 1'b0;
      iwe_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= load_weights ? LOAD_W : LOAD_X;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD_W: begin
          if (acc) begin
            wwe_q  <= 1'b1;
            data_q <= s.s_data;
            al_q   <= cnt_layer;
            an_q   <= cnt_node;
            if (cnt_last) state_q <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (!s_ready_q) begin
            state_q <= RUN;
            isel_q  <= 1'b1;
            run_q   <= '0;
          end else if (acc) begin
            iwe_q  <= 1'b1;
            data_q <= s.s_data;
            al_q   <= '0;
            an_q   <= cnt_node;
            if (node_end) s_ready_q <= 1'b0;
          end
        end
        RUN: begin
          run_q  <= run_q + RW'(1);
          isel_q <= (int'(run_q) + 1) < LAYER_SIZE;
          if (run_q == RW'(RUN_LEN - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            isel_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s.s_ready           = s_ready_q;
  assign weight_write_enable = wwe_q;
  assign input_write_enable  = iwe_q;
  assign input_select        = isel_q;
  assign addr_layer          = al_q;
  assign addr_node           = an_q;
  assign data_in             = data_q;
  assign busy                = busy_q;
  assign done                = done_q;
endmodule

// File: doc/nn_load_sequencer.md
Name: nn_load_sequencer

Overview:
- Upstream controller for the single-layer-engine neural network core.
- Accepts a word stream over a valid/ready handshake and writes it into the weight memory (layer-major, node-minor), then into the input memory.
- Then drives the core's inference window (input_select timing) and signals completion.
- Sits between the host/bus adapter and the network core; every core control pin is driven from here.

Parameters:
- LAYER_SIZE, 3, nodes per layer.
- LAYER_DEPTH, 2, number of layers (must be >= 1).
- BIT_SIZE, 8, data word width.
- RUN_TAIL, 2, extra cycles after the last compute cycle before done (core pipeline drain).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a job; ignored unless state is IDLE.
- load_weights  in  1  sampled with start: 1 = load weights then inputs; 0 = skip to inputs and reuse stored weights.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream ready.
- s_data  in  BIT_SIZE  stream word.
- weight_write_enable  out  1  to core.
- input_write_enable  out  1  to core.
- input_select  out  1  to core: 1 = layer 0 reads the input memory.
- addr_layer  out  $clog2(LAYER_DEPTH)  to core.
- addr_node  out  $clog2(LAYER_SIZE)  to core.
- data_in  out  BIT_SIZE  to core.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state=IDLE; counters=0; every output is 0, including s_ready, the write enables, input_select, the addresses, data_in, busy and done. Reset mid-job aborts immediately; no partial write is issued after rst deasserts.
- States: IDLE, LOAD_W, LOAD_X, RUN, DONE.
- IDLE:
  - start&&load_weights -> LOAD_W.
  - start&&!load_weights -> LOAD_X.
  - Counters cleared on entry.
- Handshake:
  - s_ready=1 only in LOAD_W/LOAD_X; it is a registered state decode and does not depend on s_valid.
  - A beat is accepted when s_valid&&s_ready. s_data is unconstrained when s_valid=0.
- Write latency, 1 cycle: an accepted beat registers data_in, addr_layer and addr_node and pulses the matching write enable for exactly one cycle in the following cycle. Cycles with no beat give enable=0 while data_in and the addresses hold.
- LOAD_W addressing: node counts 0..LAYER_SIZE-1; on wrap, layer increments. Exactly LAYER_SIZE*LAYER_DEPTH beats are accepted. The beat with layer=LAYER_DEPTH-1 and node=LAYER_SIZE-1 moves to LOAD_X in the same cycle; counters clear and s_ready stays 1.
- LOAD_X: addr_layer=0 and node counts 0..LAYER_SIZE-1. The last beat moves to RUN, so s_ready drops the next cycle.
- No word is dropped or duplicated across the LOAD_W->LOAD_X boundary.
- RUN:
  - Entered one cycle after the last input write, so the final write enable and RUN's first cycle do not overlap.
  - Cycle counter c runs 0..LAYER_SIZE*LAYER_DEPTH+RUN_TAIL-1.
  - input_select=1 for c<LAYER_SIZE, otherwise 0.
  - Write enables=0 and s_ready=0 throughout.
  - Terminal count -> DONE.
- DONE: done=1 for one cycle, busy=1; next state IDLE. A start in the DONE cycle is ignored.
- start asserted while busy: no effect.
- Counter widths are $clog2 of each range; the run counter is sized for LAYER_SIZE*LAYER_DEPTH+RUN_TAIL. Wrap compares use the exact terminal value, never power-of-two overflow.
- LAYER_SIZE=1 or LAYER_DEPTH=1: the terminal condition is hit on every beat and sequencing remains correct.

Decomposition:
- Package nn_pkg:
  - state enum nn_seq_state_t {IDLE, LOAD_W, LOAD_X, RUN, DONE}.
  - Width helper localparams.
- Sub-module nn_addr_counter(SIZE, DEPTH):
  - Two-level node/layer counter.
  - Inputs: inc, clr. Outputs: node, layer, last.
  - Reused for both load phases.
- Everything else is the top FSM, with registered outputs.

Test Plan (LAYER_SIZE=3, LAYER_DEPTH=2, BIT_SIZE=8, RUN_TAIL=2):
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously, state IDLE.
- Full job: start with load_weights=1, stream 0x10..0x18 with s_valid held high.
  - weight writes: (layer,node,data) = (0,0,10), (0,1,11), (0,2,12), (1,0,13), (1,1,14), (1,2,15).
  - input writes: (0,0,16), (0,1,17), (0,2,18).
  - RUN lasts 8 cycles with input_select=1 for the first 3.
  - done pulses once; busy spans start+1 through the done cycle.
- Backpressure: s_valid toggled 1,0,0,1,... -> write enables only follow accepted beats; address/data sequence identical to the full-job case; 9 enables total.
- Weight reuse: start with load_weights=0 and 3 beats -> zero weight_write_enable pulses, 3 input writes to nodes 0..2, then RUN and done.
- Ignored start: pulse start during LOAD_X and RUN -> state and counters unaffected; exactly one done.
- Reset mid-LOAD_W after 4 beats -> no further enables; a new full job then writes from (0,0) correctly.
